// File: rtl/multi_rate_tick_gen.sv
// multi_rate_tick_gen: bank of NUM_CH programmable tick / square-wave clock-enable generators
// clk_12MHz, rst: clock and sync active-high reset; en: per-channel run enable; sync: phase-align restart
// cfg_valid/cfg_ready/cfg_ch/cfg_div/cfg_mode: one-slot runtime divisor/mode reload
// tick: one-cycle pulse per period; clk_sq: square output (period 2*div) in mode 1
module multi_rate_tick_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 16,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {16'd2400, 16'd12000},
  parameter int CH_W = 3
) (
  input  logic              clk_12MHz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_sq
);
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] div [NUM_CH];
  logic [NUM_CH-1:0] mode, term, commit;
  logic pend, p_mode, discard;
  logic [CH_W-1:0] p_ch;
  logic [CNT_W-1:0] p_div;
  assign cfg_ready = ~pend;
  assign discard = pend && (32'(p_ch) >= NUM_CH);
  // an idle (disabled or frozen) target has no wrap to wait for, so it takes the update at once
  always_comb begin
    term = '0;
    commit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      term[i] = en[i] && div[i] != '0 && cnt[i] == div[i] - 1'b1;
      commit[i] = pend && 32'(p_ch) == i && (term[i] || !en[i] || div[i] == '0);
    end
  end
  always_ff @(posedge clk_12MHz) begin
    if (rst) begin
      pend <= 1'b0;
      tick <= '0;
      clk_sq <= '0;
      mode <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        div[i] <= DEF_DIV[i*CNT_W +: CNT_W];
      end
    end else begin
      if (!pend && cfg_valid) begin
        pend <= 1'b1;
        p_ch <= cfg_ch;
        p_div <= cfg_div;
        p_mode <= cfg_mode;
      end else if (sync || |commit || discard) pend <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync) begin
          cnt[i] <= '0;
          tick[i] <= 1'b0;
          clk_sq[i] <= 1'b0;
        end else begin
          tick[i] <= term[i];
          cnt[i] <= (term[i] || commit[i]) ? '0 : (en[i] && div[i] != '0) ? cnt[i] + 1'b1 : cnt[i];
          clk_sq[i] <= (!mode[i] || (commit[i] && p_mode != mode[i])) ? 1'b0 : clk_sq[i] ^ term[i];
        end
        if (pend && 32'(p_ch) == i && (sync || commit[i])) begin
          div[i] <= p_div;
          mode[i] <= p_mode;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// tb_multi_rate_tick_gen: directed self-checking bench for multi_rate_tick_gen
module tb_multi_rate_tick_gen;
  logic clk_12MHz = 1'b0;
  logic rst = 1'b1, sync = 1'b0, cfg_valid = 1'b0, cfg_mode = 1'b0;
  logic [1:0] en = 2'b11;
  logic [2:0] cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic cfg_ready;
  logic [1:0] tick, clk_sq;
  int checks = 0, errors = 0;
  always #5 clk_12MHz = ~clk_12MHz;
  multi_rate_tick_gen dut (
    .clk_12MHz(clk_12MHz), .rst(rst), .en(en), .sync(sync), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .tick(tick), .clk_sq(clk_sq)
  );
  task automatic do_reset();
    rst = 1'b1;
    sync = 1'b0;
    cfg_valid = 1'b0;
    en = 2'b11;
    repeat (3) @(negedge clk_12MHz);
    rst = 1'b0;
  endtask
  task automatic cfg_write(input logic [2:0] ch, input logic [15:0] dv, input logic md);
    cfg_valid = 1'b1;
    cfg_ch = ch;
    cfg_div = dv;
    cfg_mode = md;
    @(negedge clk_12MHz);
    cfg_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    en = 2'b11;
    repeat (3) @(negedge clk_12MHz);
    checks++; if (tick !== 2'b00) begin errors++; $display("FAIL reset_tick got %b want 00", tick); end
    checks++; if (clk_sq !== 2'b00) begin errors++; $display("FAIL reset_clk_sq got %b want 00", clk_sq); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
  endtask
  task automatic test_defaults();
    logic [1:0] exp;
    rst = 1'b0;
    for (int c = 1; c <= 12000; c++) begin
      @(negedge clk_12MHz);
      exp = {c % 2400 == 0, c == 12000};
      checks++; if (tick !== exp) begin errors++; $display("FAIL defaults c=%0d tick=%b want %b", c, tick, exp); end
    end
  endtask
  task automatic test_cfg_mid();
    int n;
    logic e;
    repeat (1000) @(negedge clk_12MHz);
    cfg_write(3'd1, 16'd10, 1'b1);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_mid_ready_drop got %b want 0", cfg_ready); end
    n = 0;
    while (n < 3000) begin
      @(negedge clk_12MHz);
      n++;
      if (tick[1]) break;
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_mid_ready_low n=%0d got %b want 0", n, cfg_ready); end
    end
    checks++; if (n !== 1399) begin errors++; $display("FAIL cfg_mid_old_period got %0d want 1399", n); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_mid_ready_back got %b want 1", cfg_ready); end
    checks++; if (clk_sq[1] !== 1'b0) begin errors++; $display("FAIL cfg_mid_sq_restart got %b want 0", clk_sq[1]); end
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk_12MHz);
      e = ((j / 10) % 2) == 1;
      checks++; if (tick[1] !== (j % 10 == 0)) begin errors++; $display("FAIL cfg_mid_tick j=%0d got %b want %b", j, tick[1], j % 10 == 0); end
      checks++; if (clk_sq[1] !== e) begin errors++; $display("FAIL cfg_mid_sq j=%0d got %b want %b", j, clk_sq[1], e); end
    end
  endtask
  task automatic test_enable();
    int n;
    do_reset();
    repeat (100) @(negedge clk_12MHz);
    en = 2'b10;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk_12MHz);
      checks++; if (tick[0] !== 1'b0) begin errors++; $display("FAIL enable_off c=%0d got %b want 0", c, tick[0]); end
    end
    en = 2'b11;
    n = 0;
    while (n < 13000) begin
      @(negedge clk_12MHz);
      n++;
      if (tick[0]) break;
    end
    checks++; if (n !== 11900) begin errors++; $display("FAIL enable_resume got %0d want 11900", n); end
    @(negedge clk_12MHz);
    checks++; if (tick[0] !== 1'b0) begin errors++; $display("FAIL enable_width got %b want 0", tick[0]); end
  endtask
  task automatic test_sync();
    logic [1:0] exp;
    do_reset();
    repeat (1230) @(negedge clk_12MHz);
    cfg_write(3'd0, 16'd6000, 1'b0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL sync_pending got %b want 0", cfg_ready); end
    repeat (3) @(negedge clk_12MHz);
    sync = 1'b1;
    @(negedge clk_12MHz);
    sync = 1'b0;
    checks++; if (tick !== 2'b00) begin errors++; $display("FAIL sync_tick got %b want 00", tick); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL sync_commit_ready got %b want 1", cfg_ready); end
    for (int c = 1; c <= 12000; c++) begin
      @(negedge clk_12MHz);
      exp = {c % 2400 == 0, c % 6000 == 0};
      checks++; if (tick !== exp) begin errors++; $display("FAIL sync_align c=%0d tick=%b want %b", c, tick, exp); end
    end
  endtask
  task automatic test_div1_div0_discard();
    int n;
    do_reset();
    repeat (5) @(negedge clk_12MHz);
    cfg_write(3'd1, 16'd1, 1'b0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL div1_ready got %b want 0", cfg_ready); end
    n = 0;
    while (n < 3000) begin
      @(negedge clk_12MHz);
      n++;
      if (tick[1]) break;
    end
    checks++; if (n !== 2394) begin errors++; $display("FAIL div1_commit got %0d want 2394", n); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL div1_ready_back got %b want 1", cfg_ready); end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_12MHz);
      checks++; if (tick[1] !== 1'b1) begin errors++; $display("FAIL div1_high j=%0d got %b want 1", j, tick[1]); end
    end
    cfg_write(3'd1, 16'd0, 1'b0);
    checks++; if (tick[1] !== 1'b1) begin errors++; $display("FAIL div0_capture_tick got %b want 1", tick[1]); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL div0_ready got %b want 0", cfg_ready); end
    @(negedge clk_12MHz);
    checks++; if (tick[1] !== 1'b1) begin errors++; $display("FAIL div0_last_tick got %b want 1", tick[1]); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL div0_ready_back got %b want 1", cfg_ready); end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_12MHz);
      checks++; if (tick[1] !== 1'b0) begin errors++; $display("FAIL div0_frozen j=%0d got %b want 0", j, tick[1]); end
    end
    cfg_write(3'd5, 16'd7, 1'b1);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL discard_ready got %b want 0", cfg_ready); end
    @(negedge clk_12MHz);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL discard_ready_back got %b want 1", cfg_ready); end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_12MHz);
      checks++; if ({tick[1], clk_sq[1]} !== 2'b00) begin errors++; $display("FAIL discard_ch1 j=%0d got %b want 00", j, {tick[1], clk_sq[1]}); end
    end
    cfg_write(3'd1, 16'd3, 1'b0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL frozen_cfg_ready got %b want 0", cfg_ready); end
    @(negedge clk_12MHz);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL frozen_cfg_commit got %b want 1", cfg_ready); end
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk_12MHz);
      checks++; if (tick[1] !== (j % 3 == 0)) begin errors++; $display("FAIL frozen_cfg_tick j=%0d got %b want %b", j, tick[1], j % 3 == 0); end
    end
  endtask
  task automatic test_rst_pending();
    logic [1:0] exp;
    do_reset();
    repeat (5) @(negedge clk_12MHz);
    cfg_write(3'd1, 16'd10, 1'b1);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstp_pending got %b want 0", cfg_ready); end
    repeat (44) @(negedge clk_12MHz);
    rst = 1'b1;
    @(negedge clk_12MHz);
    checks++; if ({tick, clk_sq} !== 4'b0000) begin errors++; $display("FAIL rstp_outputs got %b want 0000", {tick, clk_sq}); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstp_ready got %b want 1", cfg_ready); end
    @(negedge clk_12MHz);
    rst = 1'b0;
    for (int c = 1; c <= 12000; c++) begin
      @(negedge clk_12MHz);
      exp = {c % 2400 == 0, c == 12000};
      checks++; if (tick !== exp) begin errors++; $display("FAIL rstp_divs c=%0d tick=%b want %b", c, tick, exp); end
      checks++; if (clk_sq !== 2'b00) begin errors++; $display("FAIL rstp_sq c=%0d got %b want 00", c, clk_sq); end
    end
  endtask
  initial begin
    test_reset();
    test_defaults();
    test_cfg_mid();
    test_enable();
    test_sync();
    test_div1_div0_discard();
    test_rst_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
